// File: rtl/adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM state encoding and
// chunk-count helpers used to size the chunk counter.
package adder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

    function automatic int chunk_count(input int width, input int chunk);
        return width / chunk;
    endfunction

    // A single-chunk configuration still needs a 1-bit counter.
    function automatic int count_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// CHUNK-bit ripple-carry slice built from full_adder cells; also exposes the
// carry into its MSB so the parent can form signed overflow.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             cin_i,
    output logic [CHUNK-1:0] sum_o,
    output logic             cout_o,
    output logic             cmsb_o
);

    // Per-bit carry nets live in their own generate scopes to keep the chain acyclic per variable.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic c_in;
        logic c_out;
        if (i == 0) begin : g_first
            assign c_in = cin_i;
        end else begin : g_next
            assign c_in = g_bit[i-1].c_out;
        end
        full_adder u_fa (
            .a_i (a_i[i]),
            .b_i (b_i[i]),
            .c_i (c_in),
            .s_o (sum_o[i]),
            .c_o (c_out)
        );
    end

    assign cout_o = g_bit[CHUNK-1].c_out;
    assign cmsb_o = g_bit[CHUNK-1].c_in;

endmodule

// File: rtl/full_adder.sv
// Single-bit full-adder cell, the building block of the ripple chain.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i ^ c_i;
    assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));

endmodule

// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit adder processing CHUNK bits per clock through one shared slice.
// Define SUBTRACT_SUPPORT_EN to add the sub port (a - b); otherwise always a + b + cin.
//
// state | meaning
// IDLE  | ready for an operand pair
// RUN   | adding chunk cnt_q, LSB first
// DONE  | result valid, held until consumed
module chunked_seq_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SUBTRACT_SUPPORT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = chunk_count(WIDTH, CHUNK);
    localparam int CW = count_width(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic [CHUNK-1:0] a_chunk, b_chunk, slice_sum;
    logic             slice_cout, slice_cmsb;

`ifdef SUBTRACT_SUPPORT_EN
    // Two's-complement subtract: a + ~b + 1, caller's cin is ignored.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub | cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int j = 0; j < N; j++) begin
            if (cnt_q == CW'(j)) begin
                a_chunk = a_q[j*CHUNK +: CHUNK];
                b_chunk = b_q[j*CHUNK +: CHUNK];
            end
        end
    end

    chunk_adder #(
        .CHUNK (CHUNK)
    ) u_slice (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout),
        .cmsb_o (slice_cmsb)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_load;
                    carry_d = carry_load;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int j = 0; j < N; j++) begin
                    if (cnt_q == CW'(j)) begin
                        sum_d[j*CHUNK +: CHUNK] = slice_sum;
                    end
                end
                carry_d = slice_cout;
                if (cnt_q == LAST) begin
                    cout_d  = slice_cout;
                    ovf_d   = slice_cmsb ^ slice_cout;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Directed self-checking bench: a 16/4 instance for handshake and arithmetic cases,
// a 4/1 instance swept exhaustively against an arithmetic reference.
module tb_chunked_seq_adder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        in_valid0, in_ready0, cin0, out_valid0, out_ready0, cout0, ovf0;
    logic [15:0] a0, b0, sum0;
`ifdef SUBTRACT_SUPPORT_EN
    logic        sub0;
`endif

    logic        in_valid1, in_ready1, cin1, out_valid1, out_ready1, cout1, ovf1;
    logic [3:0]  a1, b1, sum1;
`ifdef SUBTRACT_SUPPORT_EN
    logic        sub1;
`endif

    chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid0),
        .in_ready  (in_ready0),
        .a         (a0),
        .b         (b0),
        .cin       (cin0),
`ifdef SUBTRACT_SUPPORT_EN
        .sub       (sub0),
`endif
        .out_valid (out_valid0),
        .out_ready (out_ready0),
        .sum       (sum0),
        .cout      (cout0),
        .ovf       (ovf0)
    );

    chunked_seq_adder #(.WIDTH(4), .CHUNK(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .a         (a1),
        .b         (b1),
        .cin       (cin1),
`ifdef SUBTRACT_SUPPORT_EN
        .sub       (sub1),
`endif
        .out_valid (out_valid1),
        .out_ready (out_ready1),
        .sum       (sum1),
        .cout      (cout1),
        .ovf       (ovf1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction on the 16/4 instance; lat = edges from accept to out_valid, -1 on timeout.
    task automatic do_op(input logic [15:0] pa, input logic [15:0] pb, input logic pc,
                         output logic [15:0] rs, output logic rc, output logic ro, output int lat);
        a0 = pa;
        b0 = pb;
        cin0 = pc;
        out_ready0 = 1'b0;
        in_valid0 = 1'b1;
        for (int i = 0; i < 20 && !in_ready0; i++) step();
        step();
        in_valid0 = 1'b0;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            if (out_valid0) break;
            step();
            if (out_valid0) lat = i;
        end
        rs = sum0;
        rc = cout0;
        ro = ovf0;
        out_ready0 = 1'b1;
        step();
        out_ready0 = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready0); end
        checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid0); end
        checks++; if (sum0 !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", sum0); end
        checks++; if (cout0 !== 1'b0) begin errors++; $display("FAIL reset_cout got=%b exp=0", cout0); end
        checks++; if (ovf0 !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf0); end
        rst = 1'b0;
        step();
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got=%b exp=1", in_ready0); end
    endtask

    task automatic test_add();
        logic [15:0] va [5] = '{16'h0000, 16'hFFFF, 16'h1234, 16'h7FFF, 16'h8000};
        logic [15:0] vb [5] = '{16'h0000, 16'h0001, 16'h4321, 16'h0001, 16'h8000};
        logic        vc [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [15:0] es [5] = '{16'h0000, 16'h0000, 16'h5556, 16'h8000, 16'h0000};
        logic        ec [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic        eo [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        for (int i = 0; i < 5; i++) begin
            do_op(va[i], vb[i], vc[i], rs, rc, ro, lat);
            checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency[%0d] got=%0d exp=4", i, lat); end
            checks++; if (rs !== es[i]) begin errors++; $display("FAIL add_sum[%0d] got=%h exp=%h", i, rs, es[i]); end
            checks++; if (rc !== ec[i]) begin errors++; $display("FAIL add_cout[%0d] got=%b exp=%b", i, rc, ec[i]); end
            checks++; if (ro !== eo[i]) begin errors++; $display("FAIL add_ovf[%0d] got=%b exp=%b", i, ro, eo[i]); end
        end
    endtask

    task automatic test_backpressure();
        bit seen = 0;
        a0 = 16'h1111;
        b0 = 16'h2222;
        cin0 = 1'b0;
        out_ready0 = 1'b0;
        in_valid0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step();
            seen = out_valid0;
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_wait_valid got=timeout exp=out_valid"); end
        for (int i = 0; i < 5; i++) begin
            a0 = 16'hFFFF;
            b0 = 16'hFFFF;
            cin0 = 1'b1;
            in_valid0 = (i % 2 == 0);
            step();
            checks++; if (sum0 !== 16'h3333) begin errors++; $display("FAIL bp_sum[%0d] got=%h exp=3333", i, sum0); end
            checks++; if (cout0 !== 1'b0 || ovf0 !== 1'b0) begin errors++; $display("FAIL bp_flags[%0d] got=%b%b exp=00", i, cout0, ovf0); end
            checks++; if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0) begin errors++; $display("FAIL bp_handshake[%0d] got=v%b r%b exp=v1 r0", i, out_valid0, in_ready0); end
        end
        in_valid0 = 1'b0;
        out_ready0 = 1'b1;
        step();
        out_ready0 = 1'b0;
        checks++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1) begin errors++; $display("FAIL bp_consume got=v%b r%b exp=v0 r1", out_valid0, in_ready0); end
    endtask

    task automatic test_back_to_back();
        int acc [3];
        int nacc = 0;
        int nres = 0;
        a0 = 16'h0001;
        b0 = 16'h0002;
        cin0 = 1'b0;
        in_valid0 = 1'b1;
        out_ready0 = 1'b1;
        for (int cyc = 0; cyc < 40 && nacc < 3; cyc++) begin
            if (out_valid0) begin
                nres++;
                checks++; if (sum0 !== 16'h0003) begin errors++; $display("FAIL b2b_sum got=%h exp=0003", sum0); end
            end
            if (in_ready0) begin
                acc[nacc] = cyc;
                nacc++;
            end
            if (nacc == 3) in_valid0 = 1'b0;
            step();
        end
        in_valid0 = 1'b0;
        out_ready0 = 1'b0;
        checks++; if (nacc != 3) begin errors++; $display("FAIL b2b_accepts got=%0d exp=3", nacc); end
        else begin
            checks++; if (acc[1] - acc[0] != 6) begin errors++; $display("FAIL b2b_interval0 got=%0d exp=6", acc[1] - acc[0]); end
            checks++; if (acc[2] - acc[1] != 6) begin errors++; $display("FAIL b2b_interval1 got=%0d exp=6", acc[2] - acc[1]); end
        end
        checks++; if (nres != 2) begin errors++; $display("FAIL b2b_results got=%0d exp=2", nres); end
        // Let the third operation drain so the block is idle afterwards.
        for (int i = 0; i < 20 && !out_valid0; i++) step();
        out_ready0 = 1'b1;
        step();
        out_ready0 = 1'b0;
    endtask

`ifdef SUBTRACT_SUPPORT_EN
    task automatic test_subtract();
        logic [15:0] va [3] = '{16'h0005, 16'h8000, 16'h0005};
        logic [15:0] vb [3] = '{16'h0007, 16'h0001, 16'h0007};
        logic        vc [3] = '{1'b0, 1'b0, 1'b1};
        logic [15:0] es [3] = '{16'hFFFE, 16'h7FFF, 16'hFFFE};
        logic        ec [3] = '{1'b0, 1'b1, 1'b0};
        logic        eo [3] = '{1'b0, 1'b1, 1'b0};
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        sub0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], vc[i], rs, rc, ro, lat);
            checks++; if (rs !== es[i]) begin errors++; $display("FAIL sub_sum[%0d] got=%h exp=%h", i, rs, es[i]); end
            checks++; if (rc !== ec[i] || ro !== eo[i]) begin errors++; $display("FAIL sub_flags[%0d] got=%b%b exp=%b%b", i, rc, ro, ec[i], eo[i]); end
        end
        sub0 = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_run();
        logic [15:0] rs;
        logic        rc, ro;
        int          lat;
        a0 = 16'hFFFF;
        b0 = 16'hFFFF;
        cin0 = 1'b0;
        in_valid0 = 1'b1;
        step();
        in_valid0 = 1'b0;
        step();
        step();
        checks++; if (sum0 !== 16'h00FE) begin errors++; $display("FAIL mid_partial_sum got=%h exp=00fe", sum0); end
        rst = 1'b1;
        step();
        checks++; if (out_valid0 !== 1'b0 || sum0 !== 16'h0000) begin errors++; $display("FAIL mid_reset got=v%b s%h exp=v0 s0000", out_valid0, sum0); end
        checks++; if (in_ready0 !== 1'b0) begin errors++; $display("FAIL mid_reset_in_ready got=%b exp=0", in_ready0); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready0 !== 1'b1) begin errors++; $display("FAIL mid_release_in_ready got=%b exp=1", in_ready0); end
        do_op(16'h00FF, 16'h0001, 1'b0, rs, rc, ro, lat);
        checks++; if (rs !== 16'h0100 || rc !== 1'b0 || ro !== 1'b0 || lat !== 4) begin
            errors++; $display("FAIL mid_followup got=%h c%b o%b lat%0d exp=0100 c0 o0 lat4", rs, rc, ro, lat);
        end
    endtask

    task automatic test_small_exhaustive();
        logic [4:0] full;
        logic [3:0] es;
        logic       eo;
        bit         seen;
        out_ready1 = 1'b0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                for (int ic = 0; ic < 2; ic++) begin
                    a1 = 4'(ia);
                    b1 = 4'(ib);
                    cin1 = 1'(ic);
                    full = 5'(ia) + 5'(ib) + 5'(ic);
                    es = full[3:0];
                    eo = (a1[3] == b1[3]) && (es[3] != a1[3]);
                    in_valid1 = 1'b1;
                    step();
                    in_valid1 = 1'b0;
                    seen = 0;
                    for (int i = 0; i < 10 && !seen; i++) begin
                        step();
                        seen = out_valid1;
                    end
                    checks++;
                    if (!seen || sum1 !== es || cout1 !== full[4] || ovf1 !== eo) begin
                        errors++;
                        $display("FAIL small a=%h b=%h c=%0d got=v%0d s%h c%b o%b exp=s%h c%b o%b",
                                 a1, b1, ic, seen, sum1, cout1, ovf1, es, full[4], eo);
                    end
                    out_ready1 = 1'b1;
                    step();
                    out_ready1 = 1'b0;
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid0 = 1'b0; out_ready0 = 1'b0; a0 = '0; b0 = '0; cin0 = 1'b0;
        in_valid1 = 1'b0; out_ready1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
`ifdef SUBTRACT_SUPPORT_EN
        sub0 = 1'b0;
        sub1 = 1'b0;
`endif
        test_reset();
        test_add();
        test_backpressure();
        test_back_to_back();
`ifdef SUBTRACT_SUPPORT_EN
        test_subtract();
`endif
        test_reset_mid_run();
        test_small_exhaustive();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/chunked_seq_adder.md
# chunked_seq_adder

Multi-cycle, parametrised two's-complement adder that processes a WIDTH-bit operand pair CHUNK bits per clock through one shared CHUNK-bit ripple-carry slice, with a registered carry between chunks. It is the sequential successor to the single-bit full-adder cell of the ripple-carry adder. It trades latency for area and sits between a valid/ready operand source and a valid/ready result sink.

## Interface
Parameters:
- WIDTH, 16, operand/result width; must be a positive multiple of CHUNK
- CHUNK, 4, bits added per cycle; 1 ≤ CHUNK ≤ WIDTH

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry-in (add mode)
- sub  in  1  subtract select (present only with SUB_EN)
- out_valid  out  1  result valid
- out_ready  in  1  sink accepts result
- sum  out  WIDTH  result
- cout  out  1  carry out of MSB (subtract: 1 = no borrow)
- ovf  out  1  signed overflow

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: in_ready=1. On in_valid&in_ready: latch a, b (b inverted if sub=1), carry reg ← cin (←1 if sub=1, cin ignored), chunk counter ← 0, → RUN.
- RUN: slice adds chunk[k] of latched A, B and carry reg; sum chunk k written into result reg, carry reg ← slice carry-out; on last chunk (k = WIDTH/CHUNK−1) also capture ovf = carry-into-MSB XOR carry-out-of-MSB, cout = carry-out; → DONE. Otherwise k ← k+1.
- DONE: out_valid=1; sum/cout/ovf held stable until out_valid&out_ready, then → IDLE.
- in_ready = (state==IDLE) & ~rst; in_valid outside IDLE ignored.
- No accept in the same cycle a result is consumed.
- Chunk indexing LSB first: chunk k = bits [k·CHUNK +: CHUNK].
- sum truncated to WIDTH bits; cout carries the WIDTH+1 bit.

## Timing
- Reset values: out_valid=0, sum=0, cout=0, ovf=0, state=IDLE, counter=0, carry=0; in_ready=0 while rst high, 1 first cycle after.
- Reset mid-RUN or mid-DONE: operation abandoned, all of the above restored at that edge; no result emitted.
- Accept at edge T0 → chunks computed at edges T0+1 … T0+N (N = WIDTH/CHUNK) → out_valid high in cycle after edge T0+N.
- With out_ready=1: consumed at edge T0+N+1, in_ready high next cycle; minimum initiation interval N+2 cycles.
- Backpressure: DONE held indefinitely, outputs bit-stable.
- CHUNK=WIDTH: N=1, latency 1 RUN cycle.

## Configuration
- SUBTRACT_SUPPORT_EN defined: sub port exists; sub=1 computes a − b (b inverted, carry-in 1, cin ignored), sub=0 computes a + b + cin.
- Not defined: no sub port; block always computes a + b + cin; subtract inversion logic absent.

## Structure
- Shared package adder_pkg: state typedef (IDLE/RUN/DONE) and chunk-count localparam helper (N = WIDTH/CHUNK, counter width = clog2(N) min 1).
- One sub-module: chunk_adder, a parametrised CHUNK-bit ripple chain built from the existing full-adder cell; outputs chunk sum, carry-out, carry into its MSB (for ovf).
- Top: FSM, counter, operand/result/carry registers, handshake logic.

## Test plan
WIDTH=16, CHUNK=4 unless stated:
- 0x0000 + 0x0000, cin=0 → sum 0x0000, cout 0, ovf 0; out_valid exactly 4 cycles after accept edge.
- 0xFFFF + 0x0001, cin=0 → sum 0x0000, cout 1, ovf 0 (carry crosses every chunk boundary); 0x1234 + 0x4321, cin=1 → 0x5556, cout 0.
- 0x7FFF + 0x0001 → sum 0x8000, cout 0, ovf 1; 0x8000 + 0x8000 → 0x0000, cout 1, ovf 1.
- out_ready low 5 cycles in DONE, in_valid pulsed with new operands → sum/cout/ovf unchanged, in_ready 0, pulses ignored; out_ready high → consumed, in_ready 1 next cycle.
- SUBTRACT_SUPPORT_EN: 0x0005 − 0x0007 → 0xFFFE, cout 0, ovf 0; 0x8000 − 0x0001 → 0x7FFF, cout 1, ovf 1; cin=1 with sub=1 has no effect.
- rst asserted after 2 RUN cycles → next cycle out_valid 0, sum 0, in_ready 1; subsequent 0x00FF + 0x0001 → 0x0100 correct. Also WIDTH=4, CHUNK=1: all 512 a/b/cin combinations vs reference model.
